// File: rtl/cve2_sleep_ctrl.sv
// cve2_sleep_ctrl: core sleep and clock-enable controller, runs on the ungated clock.
// Ports: clk_i/rst_i (async active-high), test_en_i, fetch_enable_i, core_busy_i,
//   sleep_allow_i, idle_delay_i, wake_src_i/wake_mask_i, irq_nm_i, debug_req_i in;
//   clk_en_o (core clock gate enable), fetch_enable_o, core_sleep_o, wake_cause_o,
//   sleep_count_o out.
module cve2_sleep_ctrl #(
  parameter int unsigned NumWakeSrc       = 19,
  parameter int unsigned IdleCntWidth     = 6,
  parameter int unsigned WakeSettleCycles = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    test_en_i,
  input  logic                    fetch_enable_i,
  input  logic                    core_busy_i,
  input  logic                    sleep_allow_i,
  input  logic [IdleCntWidth-1:0] idle_delay_i,
  input  logic [NumWakeSrc-1:0]   wake_src_i,
  input  logic [NumWakeSrc-1:0]   wake_mask_i,
  input  logic                    irq_nm_i,
  input  logic                    debug_req_i,
  output logic                    clk_en_o,
  output logic                    fetch_enable_o,
  output logic                    core_sleep_o,
  output logic [NumWakeSrc+1:0]   wake_cause_o,
  output logic [15:0]             sleep_count_o
);

  localparam int unsigned SettleW = (WakeSettleCycles > 1) ? $clog2(WakeSettleCycles) : 1;
  localparam logic [SettleW-1:0] SettleLoad = SettleW'(WakeSettleCycles - 1);

  typedef enum logic [2:0] {
    S_OFF,
    S_RUN,
    S_IDLE,
    S_SLEEP,
    S_WAKE
  } state_e;

  state_e                  state_q, state_d;
  logic                    busy_q;
  logic [IdleCntWidth-1:0] idle_cnt_q, idle_cnt_d;
  logic [SettleW-1:0]      settle_cnt_q, settle_cnt_d;
  logic                    fetch_en_q, fetch_en_d;
  logic [NumWakeSrc+1:0]   cause_q, cause_d;
  logic [15:0]             sleep_cnt_q;
  logic                    sleep_entry;
  logic                    clk_en;

  logic [NumWakeSrc-1:0]   wake_masked;
  logic                    wake_any;
  logic                    idle;

  assign wake_masked = wake_src_i & wake_mask_i;
  assign wake_any    = (|wake_masked) | irq_nm_i | debug_req_i;
  // Any pending wake vetoes idle, so a wake coinciding with counter expiry never sleeps.
  assign idle        = !busy_q && !wake_any && sleep_allow_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_OFF;
      busy_q       <= 1'b0;
      idle_cnt_q   <= '0;
      settle_cnt_q <= '0;
      fetch_en_q   <= 1'b0;
      cause_q      <= '0;
      sleep_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= core_busy_i;
      idle_cnt_q   <= idle_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      fetch_en_q   <= fetch_en_d;
      cause_q      <= cause_d;
      if (sleep_entry && (sleep_cnt_q != 16'hFFFF)) begin
        sleep_cnt_q <= sleep_cnt_q + 16'd1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    idle_cnt_d   = idle_cnt_q;
    settle_cnt_d = settle_cnt_q;
    fetch_en_d   = fetch_en_q;
    cause_d      = cause_q;
    sleep_entry  = 1'b0;
    clk_en       = 1'b1;

    case (state_q)
      S_OFF: begin
        clk_en = test_en_i;
        if (fetch_enable_i) begin
          fetch_en_d = 1'b1;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        if (idle) begin
          if (idle_delay_i == '0) begin
            state_d     = S_SLEEP;
            sleep_entry = 1'b1;
          end else begin
            // The RUN cycle itself counts as the first idle cycle.
            idle_cnt_d = idle_delay_i - IdleCntWidth'(1);
            state_d    = S_IDLE;
          end
        end
      end
      S_IDLE: begin
        if (!idle) begin
          idle_cnt_d = '0;
          state_d    = S_RUN;
        end else if (idle_cnt_q == '0) begin
          state_d     = S_SLEEP;
          sleep_entry = 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q - IdleCntWidth'(1);
        end
      end
      S_SLEEP: begin
        // Combinational wake path: enable rises in the same cycle as the source.
        clk_en = wake_any | busy_q | test_en_i;
        if (wake_any || busy_q) begin
          cause_d      = {debug_req_i, irq_nm_i, wake_masked};
          settle_cnt_d = SettleLoad;
          state_d      = S_WAKE;
        end
      end
      S_WAKE: begin
        if (settle_cnt_q == '0) begin
          state_d = S_RUN;
        end else begin
          settle_cnt_d = settle_cnt_q - SettleW'(1);
        end
      end
      default: begin
        state_d = S_OFF;
      end
    endcase
  end

  assign clk_en_o       = clk_en;
  assign fetch_enable_o = fetch_en_q;
  assign core_sleep_o   = fetch_en_q & !clk_en;
  assign wake_cause_o   = cause_q;
  assign sleep_count_o  = sleep_cnt_q;

endmodule

// File: tb/tb_cve2_sleep_ctrl.sv
// tb_cve2_sleep_ctrl: directed scenarios plus randomized traffic for cve2_sleep_ctrl,
// checked against a behavioural model built from idle streaks and settle countdowns.
// Ports: none (top-level bench).
module tb_cve2_sleep_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        test_en = 1'b0;
  logic        fetch_in = 1'b0;
  logic        busy = 1'b0;
  logic        allow = 1'b1;
  logic [5:0]  delay = '0;
  logic [18:0] src = '0;
  logic [18:0] mask = '0;
  logic        nmi = 1'b0;
  logic        dbg = 1'b0;

  logic        clk_en;
  logic        fetch_out;
  logic        core_sleep;
  logic [20:0] cause;
  logic [15:0] count;

  int checks = 0;
  int errors = 0;

  cve2_sleep_ctrl dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .test_en_i      (test_en),
    .fetch_enable_i (fetch_in),
    .core_busy_i    (busy),
    .sleep_allow_i  (allow),
    .idle_delay_i   (delay),
    .wake_src_i     (src),
    .wake_mask_i    (mask),
    .irq_nm_i       (nmi),
    .debug_req_i    (dbg),
    .clk_en_o       (clk_en),
    .fetch_enable_o (fetch_out),
    .core_sleep_o   (core_sleep),
    .wake_cause_o   (cause),
    .sleep_count_o  (count)
  );

  always #5 clk = ~clk;

  // Behavioural model: started / asleep flags, remaining forced-on cycles after a wake,
  // and the length of the current run of idle cycles against the delay latched at its start.
  bit          m_started;
  bit          m_asleep;
  bit          m_busy_q;
  int          m_settle;
  int          m_streak;
  int          m_target;
  int          m_count;
  logic [20:0] m_cause;

  function automatic logic m_wake_any();
    return (|(src & mask)) | nmi | dbg;
  endfunction

  function automatic logic m_clk_en();
    if (!m_started) return test_en;
    if (m_asleep) return m_wake_any() | m_busy_q | test_en;
    return 1'b1;
  endfunction

  function automatic logic m_core_sleep();
    return m_started & !m_clk_en();
  endfunction

  task automatic model_reset();
    m_started = 0; m_asleep = 0; m_busy_q = 0;
    m_settle = 0; m_streak = 0; m_target = 0; m_count = 0; m_cause = '0;
  endtask

  // One clock edge: the model consumes the same inputs the DUT samples.
  task automatic tick();
    logic wa, idl;
    @(posedge clk);
    wa  = m_wake_any();
    idl = !m_busy_q && !wa && allow;
    if (!m_started) begin
      if (fetch_in) m_started = 1;
    end else if (m_asleep) begin
      if (wa || m_busy_q) begin
        m_asleep = 0;
        m_settle = 2;
        m_cause  = {dbg, nmi, src & mask};
      end
    end else if (m_settle > 0) begin
      m_settle--;
    end else if (idl) begin
      if (m_streak == 0) m_target = int'(delay);
      m_streak++;
      if (m_streak == m_target + 1) begin
        m_asleep = 1;
        m_streak = 0;
        if (m_count < 65535) m_count++;
      end
    end else begin
      m_streak = 0;
    end
    m_busy_q = busy;
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL reset_clk_en: got %b expected 0", clk_en); end
    checks++; if (fetch_out !== 1'b0) begin errors++; $display("FAIL reset_fetch: got %b expected 0", fetch_out); end
    checks++; if (core_sleep !== 1'b0) begin errors++; $display("FAIL reset_core_sleep: got %b expected 0", core_sleep); end
    checks++; if (cause !== 21'h0) begin errors++; $display("FAIL reset_cause: got %h expected 0", cause); end
    checks++; if (count !== 16'h0) begin errors++; $display("FAIL reset_count: got %h expected 0", count); end
    test_en = 1'b1; #1;
    checks++; if (clk_en !== 1'b1) begin errors++; $display("FAIL reset_test_en: got %b expected 1", clk_en); end
    test_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_start();
    busy = 1'b1; fetch_in = 1'b1; #2;
    checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL start_off_clk_en: got %b expected 0", clk_en); end
    tick();
    fetch_in = 1'b0; #2;
    checks++; if (fetch_out !== 1'b1) begin errors++; $display("FAIL start_fetch: got %b expected 1", fetch_out); end
    checks++; if (clk_en !== 1'b1) begin errors++; $display("FAIL start_clk_en: got %b expected 1", clk_en); end
    checks++; if (core_sleep !== 1'b0) begin errors++; $display("FAIL start_core_sleep: got %b expected 0", core_sleep); end
    repeat (5) tick();
    #2;
    checks++; if (fetch_out !== 1'b1) begin errors++; $display("FAIL start_sticky: got %b expected 1", fetch_out); end
  endtask

  task automatic test_hysteresis();
    delay = 6'd3;
    busy  = 1'b0;
    tick();  // busy_q falls here
    for (int k = 1; k <= 4; k++) begin
      #2;
      checks++; if (clk_en !== 1'b1) begin errors++; $display("FAIL hyst_pre_%0d: got %b expected 1", k, clk_en); end
      tick();
    end
    #2;
    checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL hyst_clk_en: got %b expected 0", clk_en); end
    checks++; if (core_sleep !== 1'b1) begin errors++; $display("FAIL hyst_core_sleep: got %b expected 1", core_sleep); end
    checks++; if (count !== 16'd1) begin errors++; $display("FAIL hyst_count: got %0d expected 1", count); end
    checks++; if (clk_en !== m_clk_en()) begin errors++; $display("FAIL hyst_model: got %b expected %b", clk_en, m_clk_en()); end
  endtask

  task automatic test_aborted_idle();
    busy = 1'b1;
    repeat (5) tick();  // busy wakes the core, settle, back in RUN
    #2;
    checks++; if (cause !== 21'h0) begin errors++; $display("FAIL busy_wake_cause: got %h expected 0", cause); end
    delay = 6'd5;
    busy  = 1'b0;
    tick();
    tick();
    tick();
    busy = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 10; k++) begin
      #2;
      checks++; if (clk_en !== 1'b1) begin errors++; $display("FAIL abort_clk_en_%0d: got %b expected 1", k, clk_en); end
      tick();
    end
    #2;
    checks++; if (count !== 16'd1) begin errors++; $display("FAIL abort_count: got %0d expected 1", count); end
    checks++; if (core_sleep !== m_core_sleep()) begin errors++; $display("FAIL abort_model: got %b expected %b", core_sleep, m_core_sleep()); end
  endtask

  task automatic test_masked_wake();
    delay = 6'd0; busy = 1'b0;
    tick();
    tick();
    #2;
    checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL mw_asleep: got %b expected 0", clk_en); end
    src = 19'h4; mask = 19'h0;
    for (int k = 0; k < 3; k++) begin
      #2;
      checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL mw_masked_%0d: got %b expected 0", k, clk_en); end
      tick();
    end
    mask = 19'h4; #2;
    checks++; if (clk_en !== 1'b1) begin errors++; $display("FAIL mw_same_cycle: got %b expected 1", clk_en); end
    tick();
    src = 19'h0; #2;
    checks++; if (cause !== 21'h4) begin errors++; $display("FAIL mw_cause: got %h expected 4", cause); end
    checks++; if (cause !== m_cause) begin errors++; $display("FAIL mw_cause_model: got %h expected %h", cause, m_cause); end
    checks++; if (clk_en !== 1'b1) begin errors++; $display("FAIL mw_hold1: got %b expected 1", clk_en); end
    tick(); #2;
    checks++; if (clk_en !== 1'b1) begin errors++; $display("FAIL mw_hold2: got %b expected 1", clk_en); end
    tick(); #2;
    checks++; if (clk_en !== m_clk_en()) begin errors++; $display("FAIL mw_run: got %b expected %b", clk_en, m_clk_en()); end
    tick(); #2;
    checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL mw_resleep: got %b expected 0", clk_en); end
    checks++; if (count !== 16'd3) begin errors++; $display("FAIL mw_count: got %0d expected 3", count); end
  endtask

  task automatic test_nmi_debug();
    mask = 19'h0; src = 19'h7FFFF; nmi = 1'b1; dbg = 1'b1; #2;
    checks++; if (clk_en !== 1'b1) begin errors++; $display("FAIL nd_wake: got %b expected 1", clk_en); end
    tick();
    nmi = 1'b0; dbg = 1'b0; src = 19'h0; #2;
    checks++; if (cause !== 21'h180000) begin errors++; $display("FAIL nd_cause: got %h expected 180000", cause); end
    tick(); tick(); tick();
    #2;
    checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL nd_resleep: got %b expected 0", clk_en); end
    checks++; if (count !== 16'd4) begin errors++; $display("FAIL nd_count: got %0d expected 4", count); end
  endtask

  task automatic test_test_en();
    test_en = 1'b1; #2;
    checks++; if (clk_en !== 1'b1) begin errors++; $display("FAIL te_clk_en: got %b expected 1", clk_en); end
    checks++; if (core_sleep !== 1'b0) begin errors++; $display("FAIL te_core_sleep: got %b expected 0", core_sleep); end
    repeat (3) tick();
    test_en = 1'b0; #2;
    checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL te_still_asleep: got %b expected 0", clk_en); end
    checks++; if (core_sleep !== 1'b1) begin errors++; $display("FAIL te_core_sleep_back: got %b expected 1", core_sleep); end
    checks++; if (count !== 16'd4) begin errors++; $display("FAIL te_count: got %0d expected 4", count); end
  endtask

  task automatic test_saturation();
    busy = 1'b1;
    repeat (4) tick();
    // Preload the entry counter near its ceiling instead of looping 65k sleep cycles.
    force dut.sleep_cnt_q = 16'hFFFE;
    tick();
    release dut.sleep_cnt_q;
    m_count = 65534;
    #2;
    checks++; if (count !== 16'hFFFE) begin errors++; $display("FAIL sat_preload: got %h expected fffe", count); end
    busy = 1'b0;
    tick(); tick();
    #2;
    checks++; if (count !== 16'hFFFF) begin errors++; $display("FAIL sat_top: got %h expected ffff", count); end
    busy = 1'b1;
    repeat (4) tick();
    busy = 1'b0;
    tick(); tick();
    #2;
    checks++; if (count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h expected ffff", count); end
    checks++; if (count !== 16'(m_count)) begin errors++; $display("FAIL sat_model: got %h expected %h", count, 16'(m_count)); end
    checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL sat_asleep: got %b expected 0", clk_en); end
  endtask

  task automatic test_reset_in_wake();
    nmi = 1'b1;
    tick();
    nmi = 1'b0; #2;
    checks++; if (cause !== 21'h080000) begin errors++; $display("FAIL rw_cause: got %h expected 080000", cause); end
    rst = 1'b1; #1;
    checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL rw_clk_en: got %b expected 0", clk_en); end
    checks++; if (fetch_out !== 1'b0) begin errors++; $display("FAIL rw_fetch: got %b expected 0", fetch_out); end
    checks++; if (core_sleep !== 1'b0) begin errors++; $display("FAIL rw_core_sleep: got %b expected 0", core_sleep); end
    checks++; if (cause !== 21'h0) begin errors++; $display("FAIL rw_cause_clr: got %h expected 0", cause); end
    checks++; if (count !== 16'h0) begin errors++; $display("FAIL rw_count: got %h expected 0", count); end
    test_en = 1'b1; #1;
    checks++; if (clk_en !== 1'b1) begin errors++; $display("FAIL rw_test_en: got %b expected 1", clk_en); end
    test_en = 1'b0; busy = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      fetch_in = ($urandom_range(0, 15) == 0);
      busy     = ($urandom_range(0, 3) == 0);
      allow    = ($urandom_range(0, 9) != 0);
      delay    = 6'($urandom_range(0, 6));
      src      = ($urandom_range(0, 7) == 0) ? (19'h1 << $urandom_range(0, 18)) : 19'h0;
      mask     = 19'($urandom);
      nmi      = ($urandom_range(0, 39) == 0);
      dbg      = ($urandom_range(0, 39) == 0);
      test_en  = ($urandom_range(0, 19) == 0);
      #2;
      checks++; if (clk_en !== m_clk_en()) begin errors++; $display("FAIL rnd_clk_en cyc %0d: got %b expected %b", i, clk_en, m_clk_en()); end
      checks++; if (fetch_out !== m_started) begin errors++; $display("FAIL rnd_fetch cyc %0d: got %b expected %b", i, fetch_out, m_started); end
      checks++; if (core_sleep !== m_core_sleep()) begin errors++; $display("FAIL rnd_core_sleep cyc %0d: got %b expected %b", i, core_sleep, m_core_sleep()); end
      checks++; if (cause !== m_cause) begin errors++; $display("FAIL rnd_cause cyc %0d: got %h expected %h", i, cause, m_cause); end
      checks++; if (count !== 16'(m_count)) begin errors++; $display("FAIL rnd_count cyc %0d: got %0d expected %0d", i, count, m_count); end
      tick();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_start();
    test_hysteresis();
    test_aborted_idle();
    test_masked_wake();
    test_nmi_debug();
    test_test_en();
    test_saturation();
    test_reset_in_wake();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
